adrv9001_rx_burst_ctrl: RTL



---
 rtl/adrv9001_rx_burst_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/adrv9001_rx_burst_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------------------------
// adrv9001_rx_burst_ctrl: queued RX burst scheduler; macro ADRV9001_RX_BURST_TSTAMP_EN adds a
// burst start timestamp.  Rev 1.0
// ---------------------------------------------------------------------------------------------
module adrv9001_rx_burst_ctrl #(
  parameter int CMD_DEPTH = 4,
  parameter int DRAIN_MAX = 1024
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [31:0]                s_cmd_tdata,
  input  logic                       s_cmd_tvalid,
  output logic                       s_cmd_tready,
  input  logic                       abort,
  output logic                       rx_enable,
  input  logic                       rx_tvalid,
  input  logic                       rx_tlast,
  output logic                       burst_active,
  output logic                       burst_done,
  output logic [1:0]                 burst_status,
  output logic                       cmd_err,
  output logic [$clog2(CMD_DEPTH):0] cmd_level,
  output logic [31:0]                burst_tstamp
);

  localparam int c_ptr_w = $clog2(CMD_DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;
  localparam int c_drn_w = $clog2(DRAIN_MAX + 1);

  localparam logic [1:0] c_st_ok    = 2'b00;
  localparam logic [1:0] c_st_abort = 2'b01;
  localparam logic [1:0] c_st_tmo   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ENABLE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [15:0]          r_delay;
  logic [15:0]          r_len;
  logic [15:0]          r_cnt;
  logic [c_drn_w-1:0]   r_drain;
  logic                 r_aborted;
  logic                 r_done;
  logic [1:0]           r_status;
  logic                 r_cmd_err;
  logic                 r_ready_en;
  logic                 w_done;
  logic [1:0]           w_status;

  logic [31:0]          r_mem [CMD_DEPTH];
  logic [c_ptr_w-1:0]   r_wptr;
  logic [c_ptr_w-1:0]   r_rptr;
  logic [c_lvl_w-1:0]   r_level;
  logic                 w_push;
  logic                 w_store;
  logic                 w_pop;
  logic [31:0]          w_head;

  // Ready is held low until the first cycle after reset release.
  assign s_cmd_tready = r_ready_en && (r_level != c_lvl_w'(CMD_DEPTH));
  assign w_push       = s_cmd_tvalid && s_cmd_tready;
  assign w_store      = w_push && (s_cmd_tdata[15:0] != 16'd0) && !abort;
  assign w_head       = r_mem[r_rptr];
  assign w_pop        = (r_state == ST_IDLE) && (r_level != '0) && !r_done && !abort;

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wptr] <= s_cmd_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (abort) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_store) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_pop)   r_rptr <= r_rptr + c_ptr_w'(1);
      case ({w_store, w_pop})
        2'b10:   r_level <= r_level + c_lvl_w'(1);
        2'b01:   r_level <= r_level - c_lvl_w'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    w_done   = 1'b0;
    w_status = c_st_ok;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_next = (w_head[31:16] != 16'd0) ? ST_WAIT : ST_ENABLE;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          w_next   = ST_IDLE;
          w_done   = 1'b1;
          w_status = c_st_abort;
        end else if (r_delay == 16'd0) begin
          w_next = ST_ENABLE;
        end
      end
      ST_ENABLE: begin
        if (abort || (rx_tvalid && (r_cnt == r_len - 16'd1))) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A tlast coinciding with the timeout wins; an abort overrides both.
        if (rx_tlast || (r_drain == c_drn_w'(DRAIN_MAX - 1))) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
          if (r_aborted || abort) w_status = c_st_abort;
          else if (rx_tlast)      w_status = c_st_ok;
          else                    w_status = c_st_tmo;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_delay    <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_drain    <= '0;
      r_aborted  <= 1'b0;
      r_done     <= 1'b0;
      r_status   <= c_st_ok;
      r_cmd_err  <= 1'b0;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ready_en <= 1'b1;
      r_done     <= w_done;
      r_cmd_err  <= w_push && (s_cmd_tdata[15:0] == 16'd0);
      if (w_done) r_status <= w_status;

      if (w_pop) begin
        r_delay   <= w_head[31:16] - 16'd1;
        r_len     <= w_head[15:0];
        r_cnt     <= '0;
        r_aborted <= 1'b0;
      end else if ((r_state == ST_WAIT) && (r_delay != 16'd0)) begin
        r_delay <= r_delay - 16'd1;
      end

      if ((r_state == ST_ENABLE) && rx_tvalid) r_cnt <= r_cnt + 16'd1;

      r_drain <= ((r_state == ST_DRAIN) && (w_next == ST_DRAIN)) ? r_drain + c_drn_w'(1) : '0;

      if (abort && ((r_state == ST_ENABLE) || (r_state == ST_DRAIN))) r_aborted <= 1'b1;
    end
  end

  assign rx_enable    = (r_state == ST_ENABLE);
  assign burst_active = (r_state != ST_IDLE);
  assign burst_done   = r_done;
  assign burst_status = r_status;
  assign cmd_err      = r_cmd_err;
  assign cmd_level    = r_level;

`ifdef ADRV9001_RX_BURST_TSTAMP_EN
  logic [31:0] r_tcnt;
  logic [31:0] r_tstamp;

  // Captured on the edge into ENABLE so the value matches the counter in the rise cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tcnt   <= '0;
      r_tstamp <= '0;
    end else begin
      r_tcnt <= r_tcnt + 32'd1;
      if ((w_next == ST_ENABLE) && (r_state != ST_ENABLE)) r_tstamp <= r_tcnt + 32'd1;
    end
  end

  assign burst_tstamp = r_tstamp;
`else
  assign burst_tstamp = 32'd0;
`endif

endmodule
`default_nettype wire
